// File: rtl/barret_157_rr_sched.sv
// barret_157_rr_sched
//   Round-robin scheduler sharing one external combinational mod-157 Barrett
//   reducer among NUM_REQ requesters. An operand stage drives the reducer and
//   a result stage captures its residue together with the issuing requester id.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     flattened operands, requester i at [i*IN_W +: IN_W]
//   req_ready    one-hot (or zero) grant
//   red_din_a    operand to the shared reducer
//   red_dout_r   combinational residue from the reducer
//   res_valid    result valid
//   res_ready    downstream accept
//   res_data     residue
//   res_id       requester that issued the result
//   err_range    sticky residue range error
//
// Optional feature
//   BARRET_157_RR_CHECK_EN  when defined, flags any loaded residue >= PRIME on
//                           err_range (sticky until reset); otherwise tied 0.

module barret_157_rr_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IN_W    = 15,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned PRIME   = 157,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         red_din_a,
    input  logic [OUT_W-1:0]        red_dout_r,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUT_W-1:0]        res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    err_range
);

    if (PRIME < 2 || NUM_REQ < 1) begin : g_param_chk
        $error("barret_157_rr_sched: PRIME must be >= 2 and NUM_REQ >= 1");
    end

    // Operand stage
    logic            op_valid_q;
    logic [IN_W-1:0] op_data_q;
    logic [ID_W-1:0] op_id_q;

    // Result stage
    logic             res_valid_q;
    logic [OUT_W-1:0] res_data_q;
    logic [ID_W-1:0]  res_id_q;

    // Index of the most recently granted requester
    logic [ID_W-1:0] rr_ptr_q;

    logic               res_adv;
    logic               op_adv;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               xfer;
    logic [IN_W-1:0]    gnt_data;

    assign res_adv = !res_valid_q || res_ready;
    assign op_adv  = !op_valid_q || res_adv;

    if (NUM_REQ > 1) begin : g_multi
        logic [ID_W:0] idx_ext;
        logic          found;

        // Scan from rr_ptr+1 upward with wrap; first requesting index wins.
        always_comb begin
            gnt     = '0;
            gnt_id  = '0;
            found   = 1'b0;
            idx_ext = '0;
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx_ext = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
                if (idx_ext >= (ID_W + 1)'(NUM_REQ)) begin
                    idx_ext = idx_ext - (ID_W + 1)'(NUM_REQ);
                end
                if (!found && req_valid[idx_ext[ID_W-1:0]]) begin
                    found  = 1'b1;
                    gnt_id = idx_ext[ID_W-1:0];
                end
            end
            if (found && op_adv && rst_n) begin
                gnt[gnt_id] = 1'b1;
            end
        end
    end else begin : g_single
        // A lone requester is offered the slot whenever the operand stage can move.
        always_comb begin
            gnt    = '0;
            gnt_id = '0;
            gnt[0] = op_adv && rst_n;
        end
    end

    assign req_ready = gnt;
    assign xfer      = |(req_valid & gnt);
    assign gnt_data  = req_data[gnt_id*IN_W +: IN_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid_q  <= 1'b0;
            op_data_q   <= '0;
            op_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
        end else begin
            if (res_adv) begin
                res_valid_q <= op_valid_q;
                if (op_valid_q) begin
                    res_data_q <= red_dout_r;
                    res_id_q   <= op_id_q;
                end
            end
            if (op_adv) begin
                op_valid_q <= xfer;
                if (xfer) begin
                    op_data_q <= gnt_data;
                    op_id_q   <= gnt_id;
                    rr_ptr_q  <= gnt_id;
                end
            end
        end
    end

`ifdef BARRET_157_RR_CHECK_EN
    logic err_range_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_range_q <= 1'b0;
        end else if (res_adv && op_valid_q && (red_dout_r >= OUT_W'(PRIME))) begin
            err_range_q <= 1'b1;
        end
    end

    assign err_range = err_range_q;
`else
    assign err_range = 1'b0;
`endif

    assign red_din_a = op_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule
